// File: rtl/alu_seq.sv
// RV32I execute unit: add/sub, logic, slt/sltu and pass complete in one cycle; shifts iterate STEP bits per cycle.
// Latency: 1 cycle for non-shift ops, 1 + ceil(shamt/STEP) cycles for sll/srl/sra.
// Backpressure: one op in flight; o_ready only in IDLE, result held in DONE until i_ready; i_flush aborts.
module alu_seq #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_opsel,
  input  logic            i_sub,
  input  logic            i_unsigned,
  input  logic            i_arith,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_eq,
  output logic            o_lt
);

  localparam int SW = $clog2(XLEN);
  // One extra bit so that STEP == XLEN is representable.
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] STEP_C = CW'(STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_result;
  logic [SW-1:0]   r_rem;
  logic            r_left;
  logic            r_arith;
  logic            r_eq;
  logic            r_lt;

  logic            w_is_shift;
  logic [SW-1:0]   w_shamt;
  logic            w_eq;
  logic            w_lt;
  logic [XLEN-1:0] w_alu;
  logic            w_start;

  logic [CW-1:0]   w_rem_ext;
  logic [CW-1:0]   w_d;
  logic [SW-1:0]   w_rem_nxt;
  logic [XLEN-1:0] w_shl;
  logic [XLEN-1:0] w_srl;
  logic [XLEN-1:0] w_sra;
  logic [XLEN-1:0] w_acc_nxt;

  assign o_ready  = (r_state == S_IDLE);
  assign o_valid  = (r_state == S_DONE);
  assign o_result = r_result;
  assign o_eq     = r_eq;
  assign o_lt     = r_lt;

  assign w_is_shift = (i_opsel == 3'b001) || (i_opsel == 3'b101);
  assign w_shamt    = i_op2[SW-1:0];
  assign w_eq       = (i_op1 == i_op2);
  assign w_lt       = i_unsigned ? (i_op1 < i_op2) : ($signed(i_op1) < $signed(i_op2));
  // Flush wins over acceptance, so a request in a flush cycle is dropped.
  assign w_start    = o_ready & i_valid & ~i_flush;

  // Single-cycle result; shifts pass op1 through (final value when shamt is zero).
  always_comb begin
    w_alu = i_op1;
    case (i_opsel)
      3'b000:  w_alu = i_sub ? (i_op1 - i_op2) : (i_op1 + i_op2);
      3'b001:  w_alu = i_op1;
      3'b010:  w_alu = i_op2;
      3'b011:  w_alu = {{(XLEN-1){1'b0}}, w_lt};
      3'b100:  w_alu = i_op1 ^ i_op2;
      3'b101:  w_alu = i_op1;
      3'b110:  w_alu = i_op1 | i_op2;
      3'b111:  w_alu = i_op1 & i_op2;
      default: w_alu = i_op1;
    endcase
  end

  // Per-cycle shift step d = min(STEP, rem) applied to the accumulator.
  assign w_rem_ext = {1'b0, r_rem};
  assign w_d       = (w_rem_ext < STEP_C) ? w_rem_ext : STEP_C;
  assign w_rem_nxt = r_rem - w_d[SW-1:0];
  assign w_shl     = r_acc << w_d;
  assign w_srl     = r_acc >> w_d;
  assign w_sra     = $signed(r_acc) >>> w_d;
  assign w_acc_nxt = r_left ? w_shl : (r_arith ? w_sra : w_srl);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; flush returns to IDLE from anywhere.
  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (i_valid) w_state_nxt = (w_is_shift && (w_shamt != '0)) ? S_SHIFT : S_DONE;
        S_SHIFT: if (w_rem_nxt == '0) w_state_nxt = S_DONE;
        S_DONE:  if (i_ready) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Operand/flag capture at acceptance and iterative shift datapath.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc    <= '0;
      r_result <= '0;
      r_rem    <= '0;
      r_left   <= 1'b0;
      r_arith  <= 1'b0;
      r_eq     <= 1'b0;
      r_lt     <= 1'b0;
    end else if (w_start) begin
      r_acc    <= i_op1;
      r_rem    <= w_is_shift ? w_shamt : '0;
      r_left   <= (i_opsel == 3'b001);
      r_arith  <= i_arith;
      r_eq     <= w_eq;
      r_lt     <= w_lt;
      r_result <= w_alu;
    end else if ((r_state == S_SHIFT) && !i_flush) begin
      r_acc <= w_acc_nxt;
      r_rem <= w_rem_nxt;
      if (w_rem_nxt == '0) r_result <= w_acc_nxt;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
// Scoreboard bench for alu_seq: driver pushes model expectations, monitor pops on o_valid.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // STEP=1 instance (scoreboarded)
  logic        i_valid, o_ready, i_sub, i_unsigned, i_arith, i_flush, o_valid, i_ready, o_eq, o_lt;
  logic [2:0]  i_opsel;
  logic [31:0] i_op1, i_op2, o_result;

  // STEP=8 instance (directed latency checks)
  logic        v8, rdy8_o, sub8, uns8, ar8, fl8, val8_o, rdy8_i, eq8, lt8;
  logic [2:0]  op8;
  logic [31:0] a8, b8, res8;

  alu_seq #(.XLEN(32), .STEP(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_opsel(i_opsel), .i_sub(i_sub), .i_unsigned(i_unsigned), .i_arith(i_arith),
    .i_op1(i_op1), .i_op2(i_op2), .i_flush(i_flush), .o_valid(o_valid),
    .i_ready(i_ready), .o_result(o_result), .o_eq(o_eq), .o_lt(o_lt)
  );

  alu_seq #(.XLEN(32), .STEP(8)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v8), .o_ready(rdy8_o),
    .i_opsel(op8), .i_sub(sub8), .i_unsigned(uns8), .i_arith(ar8),
    .i_op1(a8), .i_op2(b8), .i_flush(fl8), .o_valid(val8_o),
    .i_ready(rdy8_i), .o_result(res8), .o_eq(eq8), .o_lt(lt8)
  );

  typedef struct {
    logic [31:0] res;
    logic        eq;
    logic        lt;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic rdy_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: architectural meaning of each opcode with plain arithmetic.
  function automatic exp_t model(input int step, input logic [2:0] op, input logic sub,
                                 input logic uns, input logic arith,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sh;
    logic lt;
    sh = int'(b[4:0]);
    lt = uns ? (a < b) : ($signed(a) < $signed(b));
    e.eq = (a == b);
    e.lt = lt;
    e.lat = 1;
    e.acc_cyc = 0;
    e.res = '0;
    case (op)
      3'd0: e.res = sub ? (a - b) : (a + b);
      3'd1: e.res = a << sh;
      3'd2: e.res = b;
      3'd3: e.res = {31'b0, lt};
      3'd4: e.res = a ^ b;
      3'd5: begin
        if (arith) e.res = $signed(a) >>> sh;
        else       e.res = a >> sh;
      end
      3'd6: e.res = a | b;
      default: e.res = a & b;
    endcase
    if (op == 3'd1 || op == 3'd5) e.lat = 1 + (sh + step - 1) / step;
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Random consumer readiness when enabled.
  initial forever begin
    @(negedge clk);
    if (rdy_rand) i_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pop on the first valid cycle, then check hold-stability while valid.
  initial begin
    exp_t cur;
    bit   seen;
    seen = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        seen = 0;
      end else if (o_valid === 1'b1 && !seen) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", {31'b0, o_valid}, 32'd0);
        end else begin
          cur = q.pop_front();
          chk("result", o_result, cur.res);
          chk("eq", {31'b0, o_eq}, {31'b0, cur.eq});
          chk("lt", {31'b0, o_lt}, {31'b0, cur.lt});
          chk("latency", 32'(cyc - cur.acc_cyc + 1), 32'(cur.lat));
        end
        seen = 1;
      end else if (o_valid === 1'b1) begin
        chk("hold_result", o_result, cur.res);
        chk("hold_ready", {31'b0, o_ready}, 32'd0);
      end else begin
        seen = 0;
      end
    end
  end

  // Present a request and hold it until accepted; call at a negedge.
  task automatic send(input logic [2:0] op, input logic sub, input logic uns, input logic arith,
                      input logic [31:0] a, input logic [31:0] b, output int waits);
    exp_t e;
    waits = 0;
    i_valid = 1'b1; i_opsel = op; i_sub = sub; i_unsigned = uns; i_arith = arith;
    i_op1 = a; i_op2 = b;
    e = model(1, op, sub, uns, arith, a, b);
    while (o_ready !== 1'b1 && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 200) begin
      chk("accept_timeout", {31'b0, o_ready}, 32'd1);
    end else begin
      e.acc_cyc = cyc + 1;
      q.push_back(e);
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_opsel = 3'($urandom); i_arith = 1'($urandom);
    i_op1 = $urandom; i_op2 = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(o_ready === 1'b1 && q.size() == 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic run8(input logic [2:0] op, input logic arith, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int explat);
    int lat;
    v8 = 1'b1; op8 = op; ar8 = arith; a8 = a; b8 = b;
    lat = 0;
    while (rdy8_o !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    @(negedge clk);
    v8 = 1'b0; a8 = $urandom; b8 = $urandom;
    lat = 1;
    while (val8_o !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    chk("s8_latency", 32'(lat), 32'(explat));
    chk("s8_result", res8, exp);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    i_valid = 0; i_opsel = 0; i_sub = 0; i_unsigned = 0; i_arith = 0;
    i_op1 = 0; i_op2 = 0; i_flush = 0; i_ready = 1;
    v8 = 0; op8 = 0; sub8 = 0; uns8 = 0; ar8 = 0; a8 = 0; b8 = 0; fl8 = 0; rdy8_i = 1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid",  {31'b0, o_valid}, 32'd0);
    chk("rst_ready",  {31'b0, o_ready}, 32'd1);
    chk("rst_result", o_result, 32'd0);
    chk("rst_eq",     {31'b0, o_eq}, 32'd0);
    chk("rst_lt",     {31'b0, o_lt}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // STEP=8 latency variants
    run8(3'b001, 1'b0, 32'h1, 32'd31, 32'h8000_0000, 5);
    run8(3'b101, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000, 2);
    run8(3'b101, 1'b0, 32'hFFFF_0000, 32'd17, 32'h0000_7FFF, 4);

    // Directed cases
    send(3'b000, 1, 0, 0, 32'h0, 32'h1, w);               wait_idle();
    send(3'b000, 0, 0, 0, 32'h0, 32'h1, w);               wait_idle();
    send(3'b101, 0, 0, 1, 32'h8000_0000, 32'd4, w);       wait_idle();
    send(3'b101, 0, 0, 0, 32'h8000_0000, 32'd4, w);       wait_idle();
    send(3'b101, 0, 0, 1, 32'h8000_0000, 32'd0, w);       wait_idle();
    send(3'b001, 0, 0, 0, 32'h1, 32'd31, w);              wait_idle();
    send(3'b011, 0, 0, 0, 32'hFFFF_FFFF, 32'h1, w);       wait_idle();
    send(3'b011, 0, 1, 0, 32'hFFFF_FFFF, 32'h1, w);       wait_idle();
    send(3'b010, 0, 0, 0, 32'h5555_AAAA, 32'h1234_5678, w); wait_idle();

    // Backpressure: hold result 10 cycles, competing request ignored
    i_ready = 1'b0;
    send(3'b100, 0, 0, 0, 32'h1234_5678, 32'h0F0F_0F0F, w);
    i_valid = 1'b1; i_opsel = 3'b000; i_sub = 0; i_op1 = 32'd3; i_op2 = 32'd4;
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", {31'b0, o_valid}, 32'd1);
      chk("bp_ready", {31'b0, o_ready}, 32'd0);
      @(negedge clk);
    end
    i_ready = 1'b1;
    send(3'b000, 0, 0, 0, 32'd3, 32'd4, w);
    chk("bp_accept_wait", 32'(w), 32'd1);
    wait_idle();

    // Flush mid-shift
    send(3'b101, 0, 0, 0, 32'hABCD_0000, 32'd20, w);
    repeat (3) @(negedge clk);
    i_flush = 1'b1; q.delete();
    @(negedge clk);
    i_flush = 1'b0;
    chk("flush_ready", {31'b0, o_ready}, 32'd1);
    chk("flush_valid", {31'b0, o_valid}, 32'd0);
    repeat (25) @(negedge clk);
    chk("flush_no_valid", {31'b0, o_valid}, 32'd0);
    send(3'b000, 0, 0, 0, 32'd3, 32'd4, w);               wait_idle();

    // Request in a flush cycle is dropped
    i_valid = 1'b1; i_opsel = 3'b000; i_op1 = 32'd5; i_op2 = 32'd6; i_flush = 1'b1;
    @(negedge clk);
    i_valid = 1'b0; i_flush = 1'b0;
    chk("flush_drop_ready", {31'b0, o_ready}, 32'd1);
    chk("flush_drop_valid", {31'b0, o_valid}, 32'd0);

    // Flush while result waits in DONE
    i_ready = 1'b0;
    send(3'b110, 0, 0, 0, 32'h00F0, 32'h0F00, w);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0; i_ready = 1'b1;
    chk("flush_done_valid", {31'b0, o_valid}, 32'd0);
    chk("flush_done_ready", {31'b0, o_ready}, 32'd1);

    // Asynchronous reset mid-shift
    send(3'b101, 0, 0, 0, 32'hABCD_0000, 32'd20, w);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0; q.delete();
    #1;
    chk("arst_valid",  {31'b0, o_valid}, 32'd0);
    chk("arst_ready",  {31'b0, o_ready}, 32'd1);
    chk("arst_result", o_result, 32'd0);
    chk("arst_lt",     {31'b0, o_lt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic with random consumer stalls
    rdy_rand = 1'b1;
    for (int n = 0; n < 150; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      send(rop, 1'($urandom), 1'($urandom), 1'($urandom), ra, rb, w);
    end
    rdy_rand = 1'b0;
    i_ready = 1'b1;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
